bm_infer_seq: RTL



---
 rtl/bm_infer_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bm_infer_seq.sv
// bm_infer_seq: sequences one inference on the Bayesian-machine chip datapath.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   cmd_*            command handshake; cmd_obs_i carries N_OBS observations
//   abort_i          cancels the operation in flight, answering with res_err_o
//   res_*            response handshake; res_scores_o holds N_CLS class scores
//   chip_ld_*        serial observation load into the chip
//   chip_start_o     one-cycle inference start pulse
//   chip_done_i      inference complete, sampled only while waiting
//   chip_rd_*        score readback; chip_rd_data_i valid one cycle after chip_rd_en_o
module bm_infer_seq #(
  parameter int N_OBS   = 8,
  parameter int OBS_W   = 8,
  parameter int N_CLS   = 4,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [N_OBS*OBS_W-1:0]   cmd_obs_i,
  input  logic                     abort_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [N_CLS*RES_W-1:0]   res_scores_o,
  output logic                     res_err_o,
  output logic                     chip_ld_en_o,
  output logic [$clog2(N_OBS)-1:0] chip_ld_addr_o,
  output logic [OBS_W-1:0]         chip_ld_data_o,
  output logic                     chip_start_o,
  input  logic                     chip_done_i,
  output logic                     chip_rd_en_o,
  output logic [$clog2(N_CLS)-1:0] chip_rd_addr_o,
  input  logic [RES_W-1:0]         chip_rd_data_i
);
  localparam int OAW = $clog2(N_OBS);
  localparam int CAW = $clog2(N_CLS);
  localparam int TW  = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, READ, DRAIN, RESP} state_t;
  state_t               state_q;
  logic [N_OBS*OBS_W-1:0] obs_q;
  logic [TW-1:0]        cnt_q, cnt_d;
  logic [OAW-1:0]       ld_nxt;
  logic [CAW-1:0]       rd_prev;
  logic                 tmo, fail;
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    tmo     = cnt_d == TW'(TIMEOUT - 1);
    ld_nxt  = chip_ld_addr_o + 1'b1;
    rd_prev = chip_rd_addr_o - 1'b1;
    // abort beats done, done beats the timeout limit
    fail    = (state_q != IDLE && state_q != RESP && abort_i) ||
              (state_q == WAIT && !chip_done_i && tmo);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      obs_q          <= '0;
      cnt_q          <= '0;
      cmd_ready_o    <= 1'b1;
      res_valid_o    <= 1'b0;
      res_err_o      <= 1'b0;
      res_scores_o   <= '0;
      chip_ld_en_o   <= 1'b0;
      chip_ld_addr_o <= '0;
      chip_ld_data_o <= '0;
      chip_start_o   <= 1'b0;
      chip_rd_en_o   <= 1'b0;
      chip_rd_addr_o <= '0;
    end else if (fail) begin
      state_q        <= RESP;
      res_valid_o    <= 1'b1;
      res_err_o      <= 1'b1;
      res_scores_o   <= '0;
      chip_ld_en_o   <= 1'b0;
      chip_ld_addr_o <= '0;
      chip_ld_data_o <= '0;
      chip_start_o   <= 1'b0;
      chip_rd_en_o   <= 1'b0;
      chip_rd_addr_o <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          state_q        <= LOAD;
          obs_q          <= cmd_obs_i;
          res_scores_o   <= '0;
          cmd_ready_o    <= 1'b0;
          chip_ld_en_o   <= 1'b1;
          chip_ld_addr_o <= '0;
          chip_ld_data_o <= cmd_obs_i[OBS_W-1:0];
        end
        LOAD: if (chip_ld_addr_o == OAW'(N_OBS - 1)) begin
          state_q        <= START;
          chip_ld_en_o   <= 1'b0;
          chip_ld_addr_o <= '0;
          chip_ld_data_o <= '0;
          chip_start_o   <= 1'b1;
        end else begin
          chip_ld_addr_o <= ld_nxt;
          chip_ld_data_o <= obs_q[int'(ld_nxt)*OBS_W +: OBS_W];
        end
        START: begin
          state_q      <= WAIT;
          chip_start_o <= 1'b0;
          cnt_q        <= '0;
        end
        WAIT: if (chip_done_i) begin
          state_q        <= READ;
          chip_rd_en_o   <= 1'b1;
          chip_rd_addr_o <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
        READ: begin
          // data for the previous address arrives this cycle
          if (chip_rd_addr_o != '0)
            res_scores_o[int'(rd_prev)*RES_W +: RES_W] <= chip_rd_data_i;
          if (chip_rd_addr_o == CAW'(N_CLS - 1)) begin
            state_q        <= DRAIN;
            chip_rd_en_o   <= 1'b0;
            chip_rd_addr_o <= '0;
          end else begin
            chip_rd_addr_o <= chip_rd_addr_o + 1'b1;
          end
        end
        DRAIN: begin
          state_q                                 <= RESP;
          res_scores_o[(N_CLS-1)*RES_W +: RES_W]  <= chip_rd_data_i;
          res_valid_o                             <= 1'b1;
          res_err_o                               <= 1'b0;
        end
        RESP: if (res_ready_i) begin
          state_q     <= IDLE;
          res_valid_o <= 1'b0;
          res_err_o   <= 1'b0;
          cmd_ready_o <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
